// File: rtl/bsg_manycore_reset_seq_pkg.sv
// Shared types and defaults for the manycore bring-up reset sequencer.
//   state_e       : sequencer FSM states (3-bit encoding)
//   default_*     : default values for the hold length and the two watchdogs
package bsg_manycore_reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_TAG = 3'd0,
    HOLD     = 3'd1,
    LOAD     = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_e;

  localparam int default_hold_cycles_lp = 3;
  localparam int default_tag_timeout_lp = 4096;
  localparam int default_run_timeout_lp = 0;
  localparam int default_ctr_width_lp   = 32;

endpackage

// File: rtl/bsg_counter_saturating.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : synchronous clear to zero
//   en_i           : count enable
//   count_o        : registered count
module bsg_counter_saturating #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i)
      count_o <= '0;
    else if (en_i && (count_o != {width_p{1'b1}}))
      count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bsg_manycore_reset_sequencer.sv
// Bring-up sequencer for the manycore harness: waits for tag programming,
// holds core reset a fixed number of cycles, enables the SPMD loader and
// counts run cycles until finish or watchdog expiry.
//   clk_i, reset_i : clock, synchronous active-high reset
//   tag_done_i     : tag programming complete (level)
//   loader_done_i  : SPMD loader finished (level)
//   finish_v_i     : finish packet received (one-cycle pulse)
//   core_reset_o   : reset to manycore array / IO complex
//   loader_en_o    : SPMD loader enable
//   running_o      : high in LOAD and RUN
//   done_o         : sticky program-finished flag
//   error_o        : sticky tag/run timeout flag
//   run_cycles_o   : cycles spent in RUN (saturating)
module bsg_manycore_reset_sequencer
  import bsg_manycore_reset_seq_pkg::*;
#(
  parameter int hold_cycles_p = default_hold_cycles_lp,
  parameter int tag_timeout_p = default_tag_timeout_lp,
  parameter int run_timeout_p = default_run_timeout_lp,
  parameter int ctr_width_p   = default_ctr_width_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   tag_done_i,
  input  logic                   loader_done_i,
  input  logic                   finish_v_i,
  output logic                   core_reset_o,
  output logic                   loader_en_o,
  output logic                   running_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic [ctr_width_p-1:0] run_cycles_o
);

  // Keep at least one bit so a disabled tag watchdog still elaborates.
  localparam int tag_w_lp = (tag_timeout_p > 0) ? $clog2(tag_timeout_p + 1) : 1;
  localparam logic [tag_w_lp-1:0]    tag_last_lp =
    tag_w_lp'((tag_timeout_p > 0) ? tag_timeout_p - 1 : 0);
  localparam logic [ctr_width_p-1:0] run_last_lp =
    ctr_width_p'((run_timeout_p > 0) ? run_timeout_p - 1 : 0);
  localparam logic [7:0]             hold_last_lp = 8'(hold_cycles_p);

  if (hold_cycles_p < 1 || hold_cycles_p > 255) begin : g_bad_hold
    $error("hold_cycles_p must be in 1..255");
  end

  state_e                 state_r;
  logic [tag_w_lp-1:0]    tag_cnt;
  logic [7:0]             hold_cnt;
  logic                   tag_to_hit, run_to_hit;

  assign tag_to_hit = (tag_timeout_p != 0) && (tag_cnt == tag_last_lp);
  assign run_to_hit = (run_timeout_p != 0) && (run_cycles_o == run_last_lp);

  bsg_counter_saturating #(.width_p(tag_w_lp)) tag_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i ((state_r != WAIT_TAG) || tag_done_i),
    .en_i    (state_r == WAIT_TAG),
    .count_o (tag_cnt)
  );

  // Cleared while outside HOLD so it starts from zero on entry.
  bsg_counter_saturating #(.width_p(8)) hold_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state_r != HOLD),
    .en_i    (state_r == HOLD),
    .count_o (hold_cnt)
  );

  // Neither the finish cycle nor the watchdog-trip cycle is counted, and
  // the count freezes once RUN is left.
  bsg_counter_saturating #(.width_p(ctr_width_p)) run_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (1'b0),
    .en_i    ((state_r == RUN) && !finish_v_i && !run_to_hit),
    .count_o (run_cycles_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= WAIT_TAG;
      core_reset_o <= 1'b1;
      loader_en_o  <= 1'b0;
      running_o    <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      case (state_r)
        WAIT_TAG: begin
          // tag_done_i wins over a same-cycle timeout
          if (tag_done_i)
            state_r <= HOLD;
          else if (tag_to_hit) begin
            state_r <= ERROR;
            error_o <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_cnt == hold_last_lp) begin
            state_r      <= LOAD;
            core_reset_o <= 1'b0;
            loader_en_o  <= 1'b1;
            running_o    <= 1'b1;
          end
        end
        LOAD: begin
          if (finish_v_i) begin
            state_r     <= DONE;
            done_o      <= 1'b1;
            running_o   <= 1'b0;
            loader_en_o <= 1'b0;
          end else if (loader_done_i)
            state_r <= RUN;
        end
        RUN: begin
          if (finish_v_i) begin
            state_r     <= DONE;
            done_o      <= 1'b1;
            running_o   <= 1'b0;
            loader_en_o <= 1'b0;
          end else if (run_to_hit) begin
            state_r      <= ERROR;
            error_o      <= 1'b1;
            core_reset_o <= 1'b1;
            running_o    <= 1'b0;
            loader_en_o  <= 1'b0;
          end
        end
        DONE, ERROR: state_r <= state_r;
        default: begin
          state_r      <= ERROR;
          error_o      <= 1'b1;
          core_reset_o <= 1'b1;
          running_o    <= 1'b0;
          loader_en_o  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  finish_pulse_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(finish_v_i && $past(finish_v_i)));
`endif

endmodule
